// File: rtl/sprite_seq_pkg.sv
// Shared types and constants for the sprite draw sequencer.
package sprite_seq_pkg;

    localparam int DEF_X_W     = 9;
    localparam int DEF_Y_W     = 8;
    localparam int DEF_C_W     = 6;
    localparam int DEF_SCORE_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        GAP,
        DONE,
        HOLD
    } seq_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/sprite_draw_sequencer_if.sv
// Channel-side bus between the sequencer and the per-sprite draw engines / VGA port.
interface sprite_draw_sequencer_if
    import sprite_seq_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int C_W     = DEF_C_W,
    parameter int SCORE_W = DEF_SCORE_W
);
    logic [N_CH-1:0]              ch_active;
    logic [N_CH-1:0][X_W-1:0]     ch_x_draw;
    logic [N_CH-1:0][Y_W-1:0]     ch_y_draw;
    logic [N_CH-1:0][C_W-1:0]     ch_colour;
    logic [N_CH-1:0]              ch_write;
    logic [N_CH-1:0]              ch_done;
    logic [N_CH-1:0][SCORE_W-1:0] ch_score;
    logic [N_CH-1:0]              ch_draw;
    logic [X_W-1:0]               x_draw;
    logic [Y_W-1:0]               y_draw;
    logic [C_W-1:0]               colour;
    logic                         VGA_write;

    modport master (
        input  ch_active, ch_x_draw, ch_y_draw, ch_colour, ch_write, ch_done, ch_score,
        output ch_draw, x_draw, y_draw, colour, VGA_write
    );

    modport slave (
        output ch_active, ch_x_draw, ch_y_draw, ch_colour, ch_write, ch_done, ch_score,
        input  ch_draw, x_draw, y_draw, colour, VGA_write
    );
endinterface

// File: rtl/next_active_sel.sv
// Priority finder: lowest active channel (start=1) or lowest active channel above cur.
module next_active_sel
    import sprite_seq_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int IW   = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
    input  logic [N_CH-1:0] ch_active,
    input  logic [IW-1:0]   cur,
    input  logic            start,
    output logic [IW-1:0]   nxt,
    output logic            vld
);
    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        nxt = '0;
        vld = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_active[i] && (start || (IW'(i) > cur))) begin
                nxt = IW'(i);
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sprite_draw_sequencer.sv
// Time-slices the VGA write port across N_CH sprite engines, skipping inactive
// channels, with per-slot timeout and a saturating score total.
module sprite_draw_sequencer
    import sprite_seq_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int SLOT_CYCLES = 256,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int C_W         = DEF_C_W,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   init,
    input  logic                   draw,
    sprite_draw_sequencer_if.master bus,
    output logic                   draw_done,
    output logic                   timeout_err,
    output logic [SCORE_W-1:0]     score
);
    localparam int CW = (clog2(SLOT_CYCLES) < 1) ? 1 : clog2(SLOT_CYCLES);
    localparam int IW = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);
    localparam int SW = SCORE_W + clog2(N_CH);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    seq_state_t        state;
    logic [IW-1:0]     cur;
    logic [IW-1:0]     nxt;
    logic              nxt_vld;
    logic [CW-1:0]     cnt;
    logic              done_i;
    logic              tmo;
    logic              keep;
    logic [X_W-1:0]    x_n;
    logic [Y_W-1:0]    y_n;
    logic [C_W-1:0]    c_n;
    logic              w_n;
    logic [SW-1:0]     sum;

    next_active_sel #(.N_CH(N_CH), .IW(IW)) u_sel (
        .ch_active (bus.ch_active),
        .cur       (cur),
        .start     (state == IDLE),
        .nxt       (nxt),
        .vld       (nxt_vld)
    );

    // A slot's last cycle (done, timeout or abort) never reaches the VGA port.
    always_comb begin
        done_i = bus.ch_done[cur];
        tmo    = (cnt == CNT_LAST);
        keep   = (state == GRANT) && draw && !done_i && !tmo;
        x_n    = keep ? bus.ch_x_draw[cur] : '0;
        y_n    = keep ? bus.ch_y_draw[cur] : '0;
        c_n    = keep ? bus.ch_colour[cur] : '0;
        w_n    = keep ? bus.ch_write[cur]  : 1'b0;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++) sum = sum + SW'(bus.ch_score[i]);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cur           <= '0;
            cnt           <= '0;
            bus.ch_draw   <= '0;
            bus.x_draw    <= '0;
            bus.y_draw    <= '0;
            bus.colour    <= '0;
            bus.VGA_write <= 1'b0;
            draw_done     <= 1'b0;
            timeout_err   <= 1'b0;
            score         <= '0;
        end else if (init) begin
            state         <= IDLE;
            cur           <= '0;
            cnt           <= '0;
            bus.ch_draw   <= '0;
            bus.x_draw    <= '0;
            bus.y_draw    <= '0;
            bus.colour    <= '0;
            bus.VGA_write <= 1'b0;
            draw_done     <= 1'b0;
            timeout_err   <= 1'b0;
            score         <= '0;
        end else begin
            bus.x_draw    <= x_n;
            bus.y_draw    <= y_n;
            bus.colour    <= c_n;
            bus.VGA_write <= w_n;
            score         <= (sum > SW'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (draw) begin
                        if (nxt_vld) begin
                            state       <= GRANT;
                            cur         <= nxt;
                            bus.ch_draw <= N_CH'(1) << nxt;
                        end else begin
                            state     <= DONE;
                            draw_done <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    if (!draw) begin
                        state       <= IDLE;
                        bus.ch_draw <= '0;
                        cnt         <= '0;
                    end else if (done_i || tmo) begin
                        state       <= GAP;
                        bus.ch_draw <= '0;
                        cnt         <= '0;
                        // done wins a tie with the timeout
                        if (!done_i) timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    cnt <= '0;
                    if (!draw) begin
                        state <= IDLE;
                    end else if (nxt_vld) begin
                        state       <= GRANT;
                        cur         <= nxt;
                        bus.ch_draw <= N_CH'(1) << nxt;
                    end else begin
                        state     <= DONE;
                        draw_done <= 1'b1;
                    end
                end
                DONE: begin
                    draw_done <= 1'b0;
                    state     <= draw ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!draw) state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    bus.ch_draw <= '0;
                    draw_done   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer: one instance at SLOT_CYCLES=256, one at 16.
module tb_sprite_draw_sequencer;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        init = 1'b0;
    logic        draw = 1'b0;
    logic        draw16 = 1'b0;
    logic        draw_done, draw_done16, tmo, tmo16;
    logic [11:0] score, score16;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    sprite_draw_sequencer_if #(.N_CH(3)) bus();
    sprite_draw_sequencer_if #(.N_CH(3)) bus16();

    sprite_draw_sequencer #(.N_CH(3), .SLOT_CYCLES(256)) u_dut (
        .clock(clock), .resetn(resetn), .init(init), .draw(draw), .bus(bus),
        .draw_done(draw_done), .timeout_err(tmo), .score(score)
    );

    sprite_draw_sequencer #(.N_CH(3), .SLOT_CYCLES(16)) u_dut16 (
        .clock(clock), .resetn(resetn), .init(init), .draw(draw16), .bus(bus16),
        .draw_done(draw_done16), .timeout_err(tmo16), .score(score16)
    );

    // Engine model: assert done in the dn_after-th cycle of a grant, if enabled.
    int         dn_after = 256;
    int         dn16_after = 4;
    logic [2:0] dn_en = 3'b111;
    logic [2:0] dn16_en = 3'b101;
    int         g[3];
    int         g16[3];

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            g[i]             = bus.ch_draw[i] ? g[i] + 1 : 0;
            bus.ch_done[i]   = dn_en[i] && bus.ch_draw[i] && (g[i] == dn_after);
            g16[i]           = bus16.ch_draw[i] ? g16[i] + 1 : 0;
            bus16.ch_done[i] = dn16_en[i] && bus16.ch_draw[i] && (g16[i] == dn16_after);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Cycle numbering: the cycle in which draw rises is cycle 1.
    int         m_first[3];
    int         m_len[3];
    logic [8:0] m_x[3];
    int         m_dd_cyc, m_dd_cnt, m_wr_bad, m_oh_bad;

    task automatic run(input bit s, input int maxc, input int tail);
        logic [2:0] cd;
        logic       dd, vw;
        logic [8:0] x;
        int         cyc;
        for (int i = 0; i < 3; i++) begin m_first[i] = 0; m_len[i] = 0; m_x[i] = '0; end
        m_dd_cyc = 0; m_dd_cnt = 0; m_wr_bad = 0; m_oh_bad = 0;
        if (s) draw16 = 1'b1; else draw = 1'b1;
        cyc = 1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clock);
            cyc++;
            cd = s ? bus16.ch_draw : bus.ch_draw;
            dd = s ? draw_done16 : draw_done;
            vw = s ? bus16.VGA_write : bus.VGA_write;
            x  = s ? bus16.x_draw : bus.x_draw;
            if ($countones(cd) > 1) m_oh_bad++;
            if (vw && cd == 3'b000) m_wr_bad++;
            for (int i = 0; i < 3; i++) begin
                if (cd[i]) begin
                    if (m_len[i] == 0) m_first[i] = cyc;
                    m_len[i]++;
                    if (m_len[i] == 5) m_x[i] = x;
                end
            end
            if (dd) begin
                m_dd_cnt++;
                if (m_dd_cyc == 0) m_dd_cyc = cyc;
            end
            if (m_dd_cyc != 0 && cyc >= m_dd_cyc + tail) break;
        end
    endtask

    task automatic release_draw();
        draw = 1'b0;
        draw16 = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int n1, k, dd;
        bus.ch_active = 3'b111;   bus16.ch_active = 3'b111;
        bus.ch_write  = 3'b111;   bus16.ch_write  = 3'b111;
        for (int i = 0; i < 3; i++) begin
            bus.ch_x_draw[i] = 9'(10 + i);   bus16.ch_x_draw[i] = 9'(10 + i);
            bus.ch_y_draw[i] = 8'(20 + i);   bus16.ch_y_draw[i] = 8'(20 + i);
            bus.ch_colour[i] = 6'(30 + i);   bus16.ch_colour[i] = 6'(30 + i);
            bus.ch_score[i]  = 12'd0;        bus16.ch_score[i]  = 12'd0;
        end

        repeat (2) @(negedge clock);
        chk("rst_ch_draw", bus.ch_draw, 0);
        chk("rst_draw_done", draw_done, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_score", score, 0);
        chk("rst_x_draw", bus.x_draw, 0);
        chk("rst_vga_write", bus.VGA_write, 0);
        resetn = 1'b1;
        @(negedge clock);

        // all active, done in the 256th cycle (ties with the timeout)
        run(0, 900, 6);
        chk("full_done_cyc", m_dd_cyc, 773);
        chk("full_done_cnt", m_dd_cnt, 1);
        chk("full_first0", m_first[0], 2);
        chk("full_first1", m_first[1], 259);
        chk("full_first2", m_first[2], 516);
        chk("full_len0", m_len[0], 256);
        chk("full_len1", m_len[1], 256);
        chk("full_len2", m_len[2], 256);
        chk("full_onehot", m_oh_bad, 0);
        chk("full_wr_outside", m_wr_bad, 0);
        chk("full_x_ch1", m_x[1], 11);
        chk("full_tie_no_tmo", tmo, 0);
        release_draw();

        // only channel 1 active
        bus.ch_active = 3'b010;
        dn_after = 20;
        run(0, 100, 2);
        chk("one_len0", m_len[0], 0);
        chk("one_len1", m_len[1], 20);
        chk("one_len2", m_len[2], 0);
        chk("one_first1", m_first[1], 2);
        chk("one_done_cyc", m_dd_cyc, 23);
        chk("one_wr_outside", m_wr_bad, 0);
        chk("one_colour_path", bus.colour, 0);
        release_draw();

        // no channel active
        bus.ch_active = 3'b000;
        run(0, 20, 3);
        chk("none_done_cyc", m_dd_cyc, 2);
        chk("none_done_cnt", m_dd_cnt, 1);
        chk("none_grants", m_len[0] + m_len[1] + m_len[2], 0);
        release_draw();

        // abort in the middle of channel 1's grant
        bus.ch_active = 3'b111;
        draw = 1'b1;
        n1 = 0; k = 0;
        while (n1 < 5 && k < 200) begin
            @(negedge clock);
            k++;
            if (bus.ch_draw == 3'b010) n1++;
        end
        chk("abort_reach_ch1", n1, 5);
        chk("lat_before", bus.x_draw, 11);
        bus.ch_x_draw[1] = 9'd77;
        chk("lat_same_cycle", bus.x_draw, 11);
        @(negedge clock);
        chk("lat_after", bus.x_draw, 77);
        draw = 1'b0;
        @(negedge clock);
        chk("abort_ch_draw", bus.ch_draw, 0);
        chk("abort_vga_write", bus.VGA_write, 0);
        chk("abort_x_draw", bus.x_draw, 0);
        dd = int'(draw_done);
        repeat (5) begin
            @(negedge clock);
            if (draw_done) dd++;
        end
        chk("abort_no_done", dd, 0);
        bus.ch_x_draw[1] = 9'd11;
        run(0, 200, 2);
        chk("restart_first0", m_first[0], 2);
        chk("restart_done_cyc", m_dd_cyc, 65);
        release_draw();

        // saturating score
        bus.ch_score[2] = 12'd4000; bus.ch_score[1] = 12'd100; bus.ch_score[0] = 12'd50;
        @(negedge clock);
        chk("score_sat", score, 4095);
        bus.ch_score[2] = 12'd10; bus.ch_score[1] = 12'd20; bus.ch_score[0] = 12'd30;
        chk("score_latency", score, 4095);
        @(negedge clock);
        chk("score_sum", score, 60);
        bus.ch_score[2] = 12'd4000; bus.ch_score[1] = 12'd94; bus.ch_score[0] = 12'd0;
        @(negedge clock);
        chk("score_edge", score, 4094);
        bus.ch_score[2] = 12'd10; bus.ch_score[1] = 12'd20; bus.ch_score[0] = 12'd30;
        @(negedge clock);

        // async reset while granting channel 0
        draw = 1'b1;
        repeat (10) @(negedge clock);
        chk("areset_pre_grant", bus.ch_draw, 1);
        #2 resetn = 1'b0;
        #1;
        chk("areset_ch_draw", bus.ch_draw, 0);
        chk("areset_x_draw", bus.x_draw, 0);
        chk("areset_vga_write", bus.VGA_write, 0);
        chk("areset_score", score, 0);
        draw = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // SLOT_CYCLES=16, channel 1 never finishes
        run(1, 100, 2);
        chk("tmo_first1", m_first[1], 7);
        chk("tmo_len1", m_len[1], 16);
        chk("tmo_first2", m_first[2], 24);
        chk("tmo_done_cyc", m_dd_cyc, 29);
        chk("tmo_flag", tmo16, 1);
        release_draw();
        chk("tmo_sticky", tmo16, 1);
        init = 1'b1;
        @(negedge clock);
        init = 1'b0;
        chk("tmo_init_clear", tmo16, 0);
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_draw_sequencer.md
Name: sprite_draw_sequencer

Overview:
Parametrised successor to the fixed three-enemy draw multiplexer. Steps through N_CH sprite channels in index order and grants the VGA write port to one channel at a time. Channels flagged inactive (dead or absent) are skipped. Each slot ends on the channel's done handshake or on a per-slot timeout. Also provides a registered, saturating sum of per-channel scores. Sits between the top-level game FSM (draw/draw_done) and the per-sprite draw engines.

Parameters:
N_CH, 3, number of sprite channels (1..16)
SLOT_CYCLES, 256, maximum clock cycles granted to one channel before forced advance
X_W, 9, VGA x coordinate width
Y_W, 8, VGA y coordinate width
C_W, 6, colour width
SCORE_W, 12, per-channel and total score width

Ports:
clock  in  1  system clock; only clock domain
resetn  in  1  asynchronous, active-low reset
init  in  1  synchronous clear, same effect as reset
draw  in  1  level request from control; held high until draw_done is seen
ch_active  in  N_CH  per-channel enable; sampled when a slot is selected
ch_x_draw  in  N_CH*X_W  packed per-channel pixel x; channel i at bits [i*X_W +: X_W]
ch_y_draw  in  N_CH*Y_W  packed per-channel pixel y
ch_colour  in  N_CH*C_W  packed per-channel colour
ch_write  in  N_CH  per-channel pixel write strobe
ch_done  in  N_CH  per-channel sprite-finished pulse
ch_score  in  N_CH*SCORE_W  packed per-channel score
ch_draw  out  N_CH  one-hot (or zero) draw grant
x_draw  out  X_W  muxed pixel x
y_draw  out  Y_W  muxed pixel y
colour  out  C_W  muxed colour
VGA_write  out  1  muxed write strobe
draw_done  out  1  one-cycle completion pulse
timeout_err  out  1  sticky flag: some slot ended by timeout; cleared by reset/init
score  out  SCORE_W  registered saturating sum of ch_score

Behaviour:
- Reset (resetn low, async) or init (sync): all outputs 0; state IDLE; slot counter 0.
- FSM states:
  - IDLE: when draw=1, select the lowest-index active channel. If one exists, go to GRANT(i); if none, go to DONE.
  - GRANT(i): ch_draw[i]=1, all other ch_draw bits 0; slot counter increments each cycle.
    - Exit when ch_done[i]=1 or counter = SLOT_CYCLES-1; the timeout exit sets timeout_err.
    - If ch_done and timeout occur in the same cycle, treat it as done; timeout_err is not set.
  - GAP: ch_draw all 0 for exactly one cycle so the engine can rearm; counter cleared.
    - Then select the next active channel with index > i and go to GRANT; if none, go to DONE.
  - DONE: draw_done=1 for exactly one cycle, then HOLD.
  - HOLD: wait for draw=0, then IDLE. A still-high draw must not restart the sequence.
- Output datapath:
  - x_draw, y_draw, colour, VGA_write are registered copies of the granted channel's inputs: 1-cycle latency from channel input to output.
  - Outside GRANT these outputs are 0; VGA_write is forced 0 in GAP, DONE, HOLD and IDLE.
  - The cycle after GRANT ends, VGA_write=0 even if the channel still drives ch_write.
- ch_active changing mid-slot does not abort the current grant; it affects only later selections.
- draw dropping in any state other than IDLE/HOLD aborts:
  - next cycle all ch_draw=0 and VGA_write=0; go to IDLE; no draw_done.
  - timeout_err keeps its value.
- Score: sum all ch_score each cycle at full width plus ceil(log2 N_CH) guard bits. If the sum exceeds 2^SCORE_W-1, output all-ones. Registered, so 1-cycle latency; reset value 0.
- Slot counter width is clog2(SLOT_CYCLES); SLOT_CYCLES=1 means every grant lasts exactly one cycle.

Decomposition:
- Package sprite_seq_pkg: state enum (IDLE, GRANT, GAP, DONE, HOLD), width constants X_W/Y_W/C_W/SCORE_W defaults, and a clog2 function.
- Sub-module next_active_sel: combinational priority finder.
  - Inputs: ch_active, current index, start flag.
  - Outputs: next index, valid.
  - Instantiated once.

Test Plan:
- N_CH=3, all active, each engine asserts ch_done after 256 cycles → grants 0,1,2 in order, each followed by a 1-cycle gap; draw_done pulses once, 773 cycles after draw rises.
- ch_active=3'b010 → only ch_draw[1] is ever asserted; draw_done follows its done; VGA_write=0 outside channel 1's window.
- ch_active=0, draw=1 → draw_done pulses the 2nd cycle after draw; no ch_draw bit is ever set.
- Channel 1 never asserts done, SLOT_CYCLES=16 → grant 1 lasts exactly 16 cycles, then channel 2 is granted; timeout_err=1 and stays 1 until init.
- draw dropped mid-grant of channel 1 → next cycle ch_draw=0, VGA_write=0; no draw_done; a new draw restarts from channel 0.
- ch_score = {4000, 100, 50} with SCORE_W=12 → score=4095 (saturated); {10, 20, 30} → 60 one cycle later. Async resetn assertion mid-GRANT clears outputs without waiting for a clock edge.
